// File: rtl/reg_file_sb.sv
// Integer register file with NRD combinational read ports, one write port, optional
// write-to-read bypass, and a per-register busy scoreboard (issue sets, writeback clears).
module reg_file_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = $clog2(NREG),
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss,
  input  logic [AW-1:0]       ia,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec
);

  localparam bit BYP = (BYPASS != 0);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Data storage; register 0 is never written so it stays 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '{default: '0};
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Busy update: issue wins over flush, flush over writeback clear.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (iss && (ia == AW'(i))) begin
        busy_nxt[i] = 1'b1;
      end else if (flush) begin
        busy_nxt[i] = 1'b0;
      end else if (we && (wa == AW'(i))) begin
        busy_nxt[i] = 1'b0;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign busy_vec = busy;

  // Read ports: a forwarded write also hides the stale busy bit.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          nz;
    logic          hit;

    assign addr = ra[k*AW +: AW];
    assign nz   = (addr != '0);
    assign hit  = BYP && we && (wa == addr) && nz;

    assign rd[k*XLEN +: XLEN] = !nz ? '0 : (hit ? wd : regs[addr]);
    assign rbusy[k]           = nz && !hit && busy[addr];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed + random bench for reg_file_sb: a BYPASS=1/NRD=4 and a BYPASS=0/NRD=2 instance
// share stimulus; expectations come from a bench-side model through a scoreboard queue.
module tb_reg_file_sb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 4;

  logic                clk;
  logic                reset_n;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd0;
  logic [NRD-1:0]      rbusy0;
  logic [2*XLEN-1:0]   rd1;
  logic [1:0]          rbusy1;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                iss;
  logic [AW-1:0]       ia;
  logic                flush;
  logic [NREG-1:0]     busy_vec0;
  logic [NREG-1:0]     busy_vec1;

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) u_byp (
    .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd0), .rbusy(rbusy0),
    .we(we), .wa(wa), .wd(wd), .iss(iss), .ia(ia), .flush(flush), .busy_vec(busy_vec0)
  );

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .BYPASS(0)) u_nob (
    .clk(clk), .reset_n(reset_n), .ra(ra[2*AW-1:0]), .rd(rd1), .rbusy(rbusy1),
    .we(we), .wa(wa), .wd(wd), .iss(iss), .ia(ia), .flush(flush), .busy_vec(busy_vec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_regs [NREG];
  logic [31:0] m_busy;

  task automatic model_clear();
    for (int i = 0; i < int'(NREG); i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  // Reference behaviour at a rising edge, from the current inputs.
  task automatic model_edge();
    logic [31:0] nb;
    nb = m_busy;
    for (int i = 1; i < int'(NREG); i++) begin
      if (iss && (int'(ia) == i))      nb[i] = 1'b1;
      else if (flush)                  nb[i] = 1'b0;
      else if (we && (int'(wa) == i))  nb[i] = 1'b0;
    end
    nb[0] = 1'b0;
    if (we && (wa != '0)) m_regs[wa] = wd;
    m_busy = nb;
  endtask

  function automatic logic [31:0] exp_rd(input int k, input bit byp);
    logic [AW-1:0] a;
    a = ra[k*AW +: AW];
    if (a == '0) return '0;
    if (byp && we && (wa == a)) return wd;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_rb(input int k, input bit byp);
    logic [AW-1:0] a;
    a = ra[k*AW +: AW];
    if (a == '0) return '0;
    if (byp && we && (wa == a)) return '0;
    return 32'(m_busy[a]);
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  // Settle, push every expected output for this cycle, then compare in order.
  task automatic check_all(input string ph);
    #1;
    for (int k = 0; k < int'(NRD); k++) begin
      push($sformatf("%s/byp_rd%0d", ph, k), exp_rd(k, 1'b1));
      push($sformatf("%s/byp_rbusy%0d", ph, k), exp_rb(k, 1'b1));
    end
    for (int k = 0; k < 2; k++) begin
      push($sformatf("%s/nob_rd%0d", ph, k), exp_rd(k, 1'b0));
      push($sformatf("%s/nob_rbusy%0d", ph, k), exp_rb(k, 1'b0));
    end
    push($sformatf("%s/byp_busy_vec", ph), m_busy);
    push($sformatf("%s/nob_busy_vec", ph), m_busy);
    for (int k = 0; k < int'(NRD); k++) begin
      pop_chk(rd0[k*XLEN +: XLEN]);
      pop_chk(32'(rbusy0[k]));
    end
    for (int k = 0; k < 2; k++) begin
      pop_chk(rd1[k*XLEN +: XLEN]);
      pop_chk(32'(rbusy1[k]));
    end
    pop_chk(busy_vec0);
    pop_chk(busy_vec1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic set_ra(input int a0, input int a1, input int a2, input int a3);
    ra = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; iss = 1'b0; ia = '0; flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    set_ra(1, 2, 3, 31);
    model_clear();
    check_all("por");
    #1 reset_n = 1'b1;

    // Fill registers, then mark a couple busy
    for (int i = 1; i < int'(NREG); i++) begin
      we = 1'b1; wa = AW'(i); wd = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    idle();
    iss = 1'b1; ia = AW'(3); tick();
    ia = AW'(10); tick();
    idle();
    set_ra(1, 3, 10, 31);
    check_all("pre_rst");

    // Asynchronous reset mid-cycle
    #1 reset_n = 1'b0;
    model_clear();
    check_all("async_rst");
    #1 reset_n = 1'b1;
    tick();
    check_all("post_rst");

    // Register 0 ignores write and issue
    set_ra(0, 0, 0, 0);
    we = 1'b1; wa = '0; wd = 32'hFFFF_FFFF; iss = 1'b1; ia = '0;
    check_all("r0_same");
    tick();
    idle();
    check_all("r0_after1");
    tick();
    check_all("r0_after2");

    // Bypass vs stored value
    we = 1'b1; wa = AW'(5); wd = 32'h0000_1111; tick();
    idle();
    set_ra(5, 5, 0, 5);
    we = 1'b1; wa = AW'(5); wd = 32'h1234_5678;
    check_all("bypass_same");
    tick();
    idle();
    check_all("bypass_after");

    // Scoreboard: issue r7, writeback four cycles later
    set_ra(7, 7, 7, 0);
    iss = 1'b1; ia = AW'(7); tick();
    idle();
    check_all("sb_c1");
    tick(); tick(); tick();
    check_all("sb_c4_pre");
    we = 1'b1; wa = AW'(7); wd = 32'h0000_CAFE;
    check_all("sb_c4_wb");
    tick();
    idle();
    check_all("sb_c5");

    // Collision: issue and writeback on the same register
    set_ra(9, 9, 2, 9);
    iss = 1'b1; ia = AW'(9); we = 1'b1; wa = AW'(9); wd = 32'd3;
    tick();
    idle();
    check_all("coll");
    iss = 1'b1; ia = AW'(2); tick();
    iss = 1'b1; ia = AW'(9); we = 1'b1; wa = AW'(9); wd = 32'd3; flush = 1'b1;
    tick();
    idle();
    check_all("coll_flush");

    // Flush clears busy, not data; a write in the flush cycle still lands
    for (int r = 3; r <= 5; r++) begin
      iss = 1'b1; ia = AW'(r); tick();
    end
    idle();
    set_ra(3, 4, 5, 4);
    check_all("pre_flush");
    flush = 1'b1; we = 1'b1; wa = AW'(6); wd = 32'h0000_0066;
    tick();
    idle();
    check_all("post_flush");
    set_ra(6, 6, 6, 6);
    check_all("flush_write");
    iss = 1'b1; ia = AW'(4); tick();
    idle();
    set_ra(4, 4, 4, 4);
    check_all("same_addr");

    // Random traffic against the model
    for (int n = 0; n < 60; n++) begin
      we    = 1'($urandom_range(0, 1));
      wa    = AW'($urandom_range(0, NREG - 1));
      wd    = $urandom;
      iss   = 1'($urandom_range(0, 1));
      ia    = AW'($urandom_range(0, NREG - 1));
      flush = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) set_ra(int'(wa), int'(ia), 0, int'(wa));
      else set_ra($urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                  $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1));
      check_all($sformatf("rnd%0d", n));
      tick();
    end
    idle();
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised integer register file with NRD combinational read ports, one write port and optional write-to-read bypass.
- Adds a per-register busy scoreboard for the pipelined core: issue marks a destination busy; writeback writes the data and clears busy.
- Sits between the decode stage (reads, busy check, issue) and the writeback stage (write).
- Replaces the fixed 32x32, 2-read register file in the pipelined build.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of registers; power of two, minimum 2.
- AW, $clog2(NREG), register address width.
- NRD, 2, number of read ports, 1 to 4.
- BYPASS, 1, 1 = a same-cycle write is visible on reads; 0 = reads return only stored values.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ra  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- rbusy  out  NRD  bit k = 1 when register ra[k] is busy (pending writeback).
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- iss  in  1  issue strobe; marks register ia busy.
- ia  in  AW  issue destination address.
- flush  in  1  clears all busy bits (pipeline squash); does not touch data.
- busy_vec  out  NREG  current busy bits, for debug.

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - All registers clear to 0 and all busy bits clear to 0 immediately.
  - rd and rbusy therefore read 0; busy_vec = 0.
  - Operation resumes on the first rising edge after reset_n returns to 1.
- Register 0:
  - Hardwired to 0. Writes to it are ignored, issue to it is ignored, and its busy bit is constantly 0.
  - rd[k] = 0 and rbusy[k] = 0 whenever ra[k] = 0, including during bypass.
- Read (combinational, zero latency):
  - When BYPASS = 1, we = 1, wa = ra[k] and wa != 0: rd[k] = wd.
  - Otherwise rd[k] = regs[ra[k]].
- Read busy (combinational):
  - rbusy[k] = busy[ra[k]], masked to 0 when BYPASS = 1 and a write to the same non-zero address occurs that cycle. The data is forwarded, so no stall is needed.
  - When BYPASS = 0, rbusy[k] reflects the stored busy bit only.
- Write (at the edge):
  - If we = 1 and wa != 0: regs[wa] <= wd and busy[wa] <= 0.
  - Latency 1 cycle to storage; 0 cycles to reads when BYPASS = 1.
- Issue (at the edge): if iss = 1 and ia != 0, busy[ia] <= 1.
- Same-edge priority for each busy bit, highest first:
  - 1. iss to that register sets it. This covers a new producer issued while an older one writes back: the data is written, busy ends at 1.
  - 2. Otherwise, flush clears it.
  - 3. Otherwise, we to that register clears it.
  - 4. Otherwise, the bit holds.
- Flush does not block a write. Data writes with we = 1 always complete.
- Issue to a register that is already busy is legal; the bit stays 1. No counting is done: a single in-flight producer per register is guaranteed by the issue stage.
- Write to a register that is not busy is legal: data updates and busy stays 0.
- Out-of-range addresses cannot occur, since NREG is a power of two.
- Multiple read ports with the same address return identical data and busy values.

Test Plan:
- Reset: write regs 1..31 with 32'hA5A5_0000+i, pulse reset_n low mid-cycle -> all rd = 0 and busy_vec = 0 before the next edge; reads after release = 0.
- Register 0: we = 1, wa = 0, wd = 32'hFFFF_FFFF with iss = 1, ia = 0 -> rd = 0, rbusy = 0 and busy_vec[0] = 0 on every later cycle.
- Bypass: BYPASS = 1, ra[0] = 5, we = 1, wa = 5, wd = 32'h1234_5678 -> rd[0] = 32'h1234_5678 in the same cycle. Repeat with BYPASS = 0 -> old value until after the edge.
- Scoreboard: iss with ia = 7 at cycle 0 -> rbusy = 1 for ra = 7 from cycle 1; we with wa = 7, wd = 32'hCAFE at cycle 4 -> rbusy = 0 in cycle 4 (BYPASS = 1) and busy_vec[7] = 0 after the edge.
- Collision: iss with ia = 9 and we with wa = 9, wd = 3 at the same edge -> regs[9] = 3 and busy_vec[9] = 1. Same edge with flush = 1 -> busy_vec[9] still 1, all other bits 0.
- Flush: set busy on 3, 4 and 5, assert flush one cycle -> busy_vec = 0 and register data unchanged. With NRD = 4, all ports on ra = 4 -> identical rd and rbusy.
